// File: rtl/a5_1_seq_ctrl.sv
// a5_1_seq_ctrl: Wishbone-slave sequencer for an A5/1 LFSR datapath.
// Drives clear, key load, frame load, mix and burst generation, and packs
// the 228-bit burst LSB-first into 32-bit words held in a small FIFO.
//
// Handshake: a bus request is accepted in any cycle where stb & cyc are high
// and ack is low. ack rises on the following cycle for exactly one cycle and
// carries the read data; wbs_dat_o is 0 in every other cycle.
`timescale 1ns/1ps
module a5_1_seq_ctrl #(
  parameter int FIFO_DEPTH = 8,
  parameter int MIX_CYCLES = 100,
  parameter int BURST_BITS = 228
) (
  input  logic        wb_clk_i,
  input  logic        wb_rst_i,
  input  logic        wbs_stb_i,
  input  logic        wbs_cyc_i,
  input  logic        wbs_we_i,
  input  logic [3:0]  wbs_sel_i,
  input  logic [31:0] wbs_dat_i,
  input  logic [31:0] wbs_adr_i,
  output logic        wbs_ack_o,
  output logic [31:0] wbs_dat_o,
  output logic        core_clear,
  output logic        core_step,
  output logic        core_majority,
  output logic        core_in_bit,
  input  logic        core_ks_bit,
  output logic        irq
);

  localparam int PW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int CW = $clog2(FIFO_DEPTH + 1);

  typedef enum logic [2:0] {
    S_IDLE, S_CLEAR, S_KEY, S_FRAME, S_MIX, S_GEN, S_FLUSH, S_DONE
  } state_t;

  state_t       state, state_nx;
  logic [15:0]  cnt, cnt_nx;

  logic [63:0]  key_reg, key_lat;
  logic [21:0]  frame_reg, frame_lat;
  logic         underflow;

  logic [31:0]  fifo_mem [FIFO_DEPTH];
  logic [PW-1:0] wr_ptr, rd_ptr;
  logic [CW-1:0] fifo_count;

  logic [31:0]  shift_word;
  logic [4:0]   bit_pos;
  logic         cap_en;

  // Bus decode
  logic        req, wr_acc, rd_acc, ctrl_wr, do_start, do_abort, flush, pop_req;
  logic [2:0]  reg_idx;
  logic        busy, done;

  assign req      = wbs_stb_i & wbs_cyc_i & ~wbs_ack_o;
  assign wr_acc   = req & wbs_we_i;
  assign rd_acc   = req & ~wbs_we_i;
  assign reg_idx  = wbs_adr_i[4:2];
  assign ctrl_wr  = wr_acc & (reg_idx == 3'd0);
  assign do_abort = ctrl_wr & wbs_dat_i[1];
  assign do_start = ctrl_wr & wbs_dat_i[0] & ~wbs_dat_i[1] &
                    ((state == S_IDLE) | (state == S_DONE));
  assign flush    = do_start | do_abort;
  assign pop_req  = rd_acc & (reg_idx == 3'd4);

  assign done = (state == S_DONE);
  assign busy = (state != S_IDLE) & (state != S_DONE);
  assign irq  = done;

  function automatic logic [31:0] lane_merge(input logic [31:0] old_v,
                                             input logic [31:0] new_v,
                                             input logic [3:0]  sel);
    logic [31:0] r;
    r = old_v;
    for (int b = 0; b < 4; b++)
      if (sel[b]) r[b*8 +: 8] = new_v[b*8 +: 8];
    return r;
  endfunction

  logic [31:0] frame_merged;
  assign frame_merged = lane_merge({10'b0, frame_reg}, wbs_dat_i, wbs_sel_i);

  // FSM state register
  always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
    if (wb_rst_i) begin
      state <= S_IDLE;
      cnt   <= '0;
    end else begin
      state <= state_nx;
      cnt   <= cnt_nx;
    end
  end

  // Next-state logic and per-cycle core strobes
  always_comb begin
    state_nx      = state;
    cnt_nx        = cnt;
    core_clear    = 1'b0;
    core_step     = 1'b0;
    core_majority = 1'b0;
    core_in_bit   = 1'b0;
    case (state)
      S_IDLE: begin
        if (do_start) begin
          state_nx = S_CLEAR;
          cnt_nx   = '0;
        end
      end
      S_CLEAR: begin
        core_clear = 1'b1;
        state_nx   = S_KEY;
        cnt_nx     = '0;
      end
      S_KEY: begin
        core_step   = 1'b1;
        core_in_bit = key_lat[cnt[5:0]];
        if (cnt == 16'd63) begin
          state_nx = S_FRAME;
          cnt_nx   = '0;
        end else begin
          cnt_nx = cnt + 16'd1;
        end
      end
      S_FRAME: begin
        core_step   = 1'b1;
        core_in_bit = frame_lat[cnt[4:0]];
        if (cnt == 16'd21) begin
          state_nx = S_MIX;
          cnt_nx   = '0;
        end else begin
          cnt_nx = cnt + 16'd1;
        end
      end
      S_MIX: begin
        core_step     = 1'b1;
        core_majority = 1'b1;
        if (cnt == 16'(MIX_CYCLES - 1)) begin
          state_nx = S_GEN;
          cnt_nx   = '0;
        end else begin
          cnt_nx = cnt + 16'd1;
        end
      end
      S_GEN: begin
        core_step     = 1'b1;
        core_majority = 1'b1;
        if (cnt == 16'(BURST_BITS - 1)) begin
          state_nx = S_FLUSH;
          cnt_nx   = '0;
        end else begin
          cnt_nx = cnt + 16'd1;
        end
      end
      S_FLUSH: begin
        state_nx = S_DONE;
      end
      S_DONE: begin
        if (do_start) begin
          state_nx = S_CLEAR;
          cnt_nx   = '0;
        end
      end
      default: state_nx = S_IDLE;
    endcase
    if (do_abort) begin
      state_nx = S_IDLE;
      cnt_nx   = '0;
    end
  end

  // Keystream capture: each GEN step's output is sampled one cycle later,
  // so the last bit lands in FLUSH, which also pushes any partial word.
  logic        cap_valid, push, push_ok, pop_ok, fifo_full, fifo_empty;
  logic [31:0] cap_word;

  assign cap_valid  = cap_en & ((state == S_GEN) | (state == S_FLUSH));
  assign cap_word   = shift_word | (32'(core_ks_bit) << bit_pos);
  assign push       = cap_valid & ((bit_pos == 5'd31) | (state == S_FLUSH));
  assign fifo_full  = (fifo_count == CW'(FIFO_DEPTH));
  assign fifo_empty = (fifo_count == '0);
  assign push_ok    = push & ~fifo_full & ~flush;
  assign pop_ok     = pop_req & ~fifo_empty;

  // Shift word assembly and capture pipeline flag
  always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
    if (wb_rst_i) begin
      shift_word <= '0;
      bit_pos    <= '0;
      cap_en     <= 1'b0;
    end else begin
      cap_en <= (state == S_GEN) & ~do_abort;
      if (flush) begin
        shift_word <= '0;
        bit_pos    <= '0;
      end else if (cap_valid) begin
        shift_word <= push ? 32'd0 : cap_word;
        bit_pos    <= bit_pos + 5'd1;
      end
    end
  end

  // FIFO storage (contents need no reset; pointers/count gate visibility)
  always_ff @(posedge wb_clk_i) begin
    if (push_ok) fifo_mem[wr_ptr] <= cap_word;
  end

  // FIFO pointers and occupancy
  always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
    if (wb_rst_i) begin
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      fifo_count <= '0;
    end else if (flush) begin
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      fifo_count <= '0;
    end else begin
      if (push_ok)
        wr_ptr <= (wr_ptr == PW'(FIFO_DEPTH - 1)) ? '0 : wr_ptr + 1'b1;
      if (pop_ok)
        rd_ptr <= (rd_ptr == PW'(FIFO_DEPTH - 1)) ? '0 : rd_ptr + 1'b1;
      case ({push_ok, pop_ok})
        2'b10:   fifo_count <= fifo_count + 1'b1;
        2'b01:   fifo_count <= fifo_count - 1'b1;
        default: fifo_count <= fifo_count;
      endcase
    end
  end

  // Software-visible registers and start-time snapshot of key/frame
  always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
    if (wb_rst_i) begin
      key_reg   <= '0;
      frame_reg <= '0;
      key_lat   <= '0;
      frame_lat <= '0;
      underflow <= 1'b0;
    end else begin
      if (wr_acc && reg_idx == 3'd1)
        key_reg[31:0] <= lane_merge(key_reg[31:0], wbs_dat_i, wbs_sel_i);
      if (wr_acc && reg_idx == 3'd2)
        key_reg[63:32] <= lane_merge(key_reg[63:32], wbs_dat_i, wbs_sel_i);
      if (wr_acc && reg_idx == 3'd3)
        frame_reg <= frame_merged[21:0];
      if (do_start) begin
        key_lat   <= key_reg;
        frame_lat <= frame_reg;
      end
      if (pop_req && fifo_empty)
        underflow <= 1'b1;
      else if (ctrl_wr && wbs_dat_i[2])
        underflow <= 1'b0;
    end
  end

  // Read data selection
  logic [31:0] count_ext, rd_val;
  assign count_ext = 32'(fifo_count);

  always_comb begin
    rd_val = '0;
    case (reg_idx)
      3'd0: rd_val = {24'b0, count_ext[3:0], 1'b0, underflow, done, busy};
      3'd1: rd_val = key_reg[31:0];
      3'd2: rd_val = key_reg[63:32];
      3'd3: rd_val = {10'b0, frame_reg};
      3'd4: rd_val = fifo_empty ? 32'd0 : fifo_mem[rd_ptr];
      default: rd_val = '0;
    endcase
  end

  // Bus response: one-cycle ack, data only alongside a read ack
  always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
    if (wb_rst_i) begin
      wbs_ack_o <= 1'b0;
      wbs_dat_o <= '0;
    end else begin
      wbs_ack_o <= req;
      wbs_dat_o <= rd_acc ? rd_val : 32'd0;
    end
  end

  logic unused_bits;
  assign unused_bits = ^{wbs_adr_i[31:5], wbs_adr_i[1:0], count_ext[31:4], frame_merged[31:22]};

endmodule

// File: tb/tb_a5_1_seq_ctrl.sv
// Directed testbench for a5_1_seq_ctrl with a behavioural A5/1 core attached.
`timescale 1ns/1ps
module tb_a5_1_seq_ctrl;

  // Clock and reset
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  logic        stb = 0, cyc = 0, we = 0;
  logic [3:0]  sel = 4'hF;
  logic [31:0] wdat = 0, adr = 0;
  logic        ack;
  logic [31:0] rdat_o;
  logic        core_clear, core_step, core_majority, core_in_bit, core_ks_bit, irq;

  a5_1_seq_ctrl dut (
    .wb_clk_i(clk), .wb_rst_i(rst),
    .wbs_stb_i(stb), .wbs_cyc_i(cyc), .wbs_we_i(we), .wbs_sel_i(sel),
    .wbs_dat_i(wdat), .wbs_adr_i(adr),
    .wbs_ack_o(ack), .wbs_dat_o(rdat_o),
    .core_clear(core_clear), .core_step(core_step),
    .core_majority(core_majority), .core_in_bit(core_in_bit),
    .core_ks_bit(core_ks_bit), .irq(irq)
  );

  // A5/1 model: state packs R1[18:0], R2[21:0], R3[22:0] from MSB down
  function automatic logic [63:0] a5_next(input logic [63:0] s, input logic maj, input logic inb);
    logic [18:0] r1; logic [21:0] r2; logic [22:0] r3;
    logic c1, c2, c3, m;
    r1 = s[63:45]; r2 = s[44:23]; r3 = s[22:0];
    c1 = r1[8]; c2 = r2[10]; c3 = r3[10];
    m  = (c1 & c2) | (c1 & c3) | (c2 & c3);
    if (!maj || c1 == m) r1 = {r1[17:0], r1[18] ^ r1[17] ^ r1[16] ^ r1[13] ^ inb};
    if (!maj || c2 == m) r2 = {r2[20:0], r2[21] ^ r2[20] ^ inb};
    if (!maj || c3 == m) r3 = {r3[21:0], r3[22] ^ r3[21] ^ r3[20] ^ r3[7] ^ inb};
    return {r1, r2, r3};
  endfunction

  function automatic logic a5_ks(input logic [63:0] s);
    return s[63] ^ s[44] ^ s[22];
  endfunction

  logic        stub_one = 1'b1;
  logic [63:0] core_s;
  always @(posedge clk or posedge rst) begin
    if (rst) core_s <= '0;
    else if (core_clear) core_s <= '0;
    else if (core_step) core_s <= a5_next(core_s, core_majority, core_in_bit);
  end
  assign core_ks_bit = stub_one ? 1'b1 : a5_ks(core_s);

  // Cycle counter and strobe monitor
  int cyc_cnt = 0;
  always @(posedge clk) cyc_cnt <= cyc_cnt + 1;

  logic        mon_en = 0;
  int          step_cnt, maj_cnt, clr_cnt, load_idx, inb_mix;
  logic [85:0] load_vec;
  always @(negedge clk) begin
    if (mon_en) begin
      if (core_step) step_cnt++;
      if (core_majority) maj_cnt++;
      if (core_clear) clr_cnt++;
      if (core_majority && core_in_bit) inb_mix++;
      if (core_step && !core_majority) begin
        if (load_idx < 86) load_vec[load_idx] = core_in_bit;
        load_idx++;
      end
    end
  end

  // Scoreboard
  int errors = 0;
  int checks = 0;
  logic [31:0] exp_q[$];
  int acc_n;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] want);
    checks++;
    assert (obs === want) else begin
      errors++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, want);
    end
  endtask

  task automatic gen_expected(input logic [63:0] k, input logic [21:0] f);
    logic [63:0] s;
    logic [31:0] w;
    s = '0;
    w = '0;
    exp_q.delete();
    for (int i = 0; i < 64; i++) s = a5_next(s, 1'b0, k[i]);
    for (int j = 0; j < 22; j++) s = a5_next(s, 1'b0, f[j]);
    for (int i = 0; i < 100; i++) s = a5_next(s, 1'b1, 1'b0);
    for (int b = 0; b < 228; b++) begin
      s = a5_next(s, 1'b1, 1'b0);
      w[b % 32] = a5_ks(s);
      if ((b % 32) == 31 || b == 227) begin
        exp_q.push_back(w);
        w = '0;
      end
    end
  endtask

  // Driver tasks
  task automatic wb_xfer(input logic w_en, input logic [31:0] a, input logic [31:0] d,
                         input logic [3:0] s, output logic [31:0] r);
    int n;
    @(negedge clk);
    stb = 1; cyc = 1; we = w_en; adr = a; wdat = d; sel = s;
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!ack && n < 8);
    if (!ack) chk("ack_timeout", 32'(ack), 32'd1);
    r = rdat_o;
    acc_n = cyc_cnt;
    stb = 0; cyc = 0; we = 0; sel = 4'hF;
  endtask

  task automatic wb_wr(input logic [31:0] a, input logic [31:0] d);
    logic [31:0] r;
    wb_xfer(1'b1, a, d, 4'hF, r);
  endtask

  task automatic wb_rd(input logic [31:0] a, output logic [31:0] r);
    wb_xfer(1'b0, a, 32'd0, 4'hF, r);
  endtask

  task automatic wait_until(input int target);
    while (cyc_cnt < target) @(negedge clk);
  endtask

  task automatic wait_irq(output int edge_n);
    int n;
    n = 0;
    while (!irq && n < 600) begin
      @(negedge clk);
      n++;
    end
    edge_n = irq ? cyc_cnt : -100000;
  endtask

  task automatic drain_check(input string tag);
    logic [31:0] d;
    for (int i = 0; i < 8; i++) begin
      wb_rd(32'h10, d);
      chk($sformatf("%s_word%0d", tag, i), d, (exp_q.size() > 0) ? exp_q.pop_front() : 32'hDEAD_BEEF);
    end
  endtask

  initial begin
    logic [31:0] d;
    logic [85:0] exp_load;
    logic [31:0] c0, c1;
    int st, de;

    // Reset state
    repeat (3) @(negedge clk);
    chk("rst_core_outs", {27'd0, core_clear, core_step, core_majority, core_in_bit, irq}, 32'd0);
    rst = 0;
    chk("rst_ack_dat", {ack, rdat_o[30:0]}, 32'd0);
    wb_rd(32'h00, d); chk("rst_ctrl", d, 32'h0);
    wb_rd(32'h04, d); chk("rst_key_lo", d, 32'h0);
    @(negedge clk);
    chk("ack_one_cycle", {ack, rdat_o[30:0]}, 32'd0);

    // Register access
    wb_wr(32'h04, 32'h89AB_CDEF);
    wb_wr(32'h08, 32'h1223_4567);
    wb_xfer(1'b1, 32'h08, 32'h0000_5500, 4'b0010, d);
    wb_rd(32'h08, d); chk("key_hi_lane", d, 32'h1223_5567);
    wb_wr(32'h08, 32'h1223_4567);
    wb_wr(32'h0C, 32'hFFFF_FFFF);
    wb_rd(32'h0C, d); chk("frame_mask", d, 32'h003F_FFFF);
    wb_wr(32'h0C, 32'h0000_0134);
    wb_rd(32'h14, d); chk("unmapped_rd", d, 32'h0);
    wb_wr(32'h18, 32'h5555_5555);
    wb_rd(32'h104, d); chk("alias_key_lo", d, 32'h89AB_CDEF);

    // Stub core (ks=1): timing, FIFO contents, strobe sequencing
    stub_one = 1;
    step_cnt = 0; maj_cnt = 0; clr_cnt = 0; load_idx = 0; inb_mix = 0;
    mon_en = 1;
    wb_wr(32'h00, 32'h1);
    st = acc_n;
    wait_irq(de);
    mon_en = 0;
    chk("stub_done_time", 32'(de - st), 32'd416);
    chk("stub_irq", 32'(irq), 32'd1);
    chk("step_count", 32'(step_cnt), 32'd414);
    chk("maj_count", 32'(maj_cnt), 32'd328);
    chk("clear_count", 32'(clr_cnt), 32'd1);
    chk("load_count", 32'(load_idx), 32'd86);
    chk("inbit_in_mix", 32'(inb_mix), 32'd0);
    exp_load = {22'h134, 64'h1223_4567_89AB_CDEF};
    c0 = exp_load[31:0];  c1 = load_vec[31:0];  chk("load_bits_lo", c1, c0);
    c0 = exp_load[63:32]; c1 = load_vec[63:32]; chk("load_bits_mid", c1, c0);
    c0 = {10'd0, exp_load[85:64]}; c1 = {10'd0, load_vec[85:64]}; chk("load_bits_hi", c1, c0);
    wb_rd(32'h00, d); chk("stub_ctrl_done", d, 32'h82);
    exp_q.delete();
    for (int i = 0; i < 7; i++) exp_q.push_back(32'hFFFF_FFFF);
    exp_q.push_back(32'h0000_000F);
    drain_check("stub");
    wb_rd(32'h10, d); chk("stub_9th_read", d, 32'h0);
    wb_rd(32'h00, d); chk("stub_ctrl_uflow", d, 32'h06);
    wb_wr(32'h00, 32'h4);
    wb_rd(32'h00, d); chk("stub_uflow_clr", d, 32'h02);

    // Golden core run with a start rewrite during GEN
    stub_one = 0;
    gen_expected(64'h1223_4567_89AB_CDEF, 22'h134);
    wb_wr(32'h00, 32'h1);
    st = acc_n;
    wait_until(st + 200);
    wb_wr(32'h00, 32'h1);
    wait_irq(de);
    chk("gold_done_time", 32'(de - st), 32'd416);
    wb_rd(32'h00, d); chk("gold_ctrl_done", d, 32'h82);
    drain_check("gold");
    wb_rd(32'h10, d); chk("gold_9th_read", d, 32'h0);
    wb_rd(32'h00, d); chk("gold_ctrl_uflow", d, 32'h06);
    wb_wr(32'h00, 32'h4);
    wb_rd(32'h00, d); chk("gold_uflow_clr", d, 32'h02);

    // Start from DONE flushes stale words, then abort during MIX
    wb_wr(32'h00, 32'h1);
    wait_irq(de);
    wb_rd(32'h00, d); chk("stale_ctrl", d, 32'h82);
    wb_wr(32'h00, 32'h1);
    wb_rd(32'h00, d); chk("restart_flush", d, 32'h01);
    st = acc_n;
    wait_until(st + 110);
    wb_wr(32'h00, 32'h2);
    chk("abort_core_outs", {28'd0, core_clear, core_step, core_majority, irq}, 32'd0);
    wb_rd(32'h00, d); chk("abort_ctrl", d, 32'h00);
    gen_expected(64'h1223_4567_89AB_CDEF, 22'h134);
    wb_wr(32'h00, 32'h1);
    st = acc_n;
    wait_irq(de);
    chk("post_abort_time", 32'(de - st), 32'd416);
    wb_rd(32'h00, d); chk("post_abort_ctrl", d, 32'h82);
    drain_check("post_abort");

    // Asynchronous reset in the middle of GEN
    wb_wr(32'h00, 32'h1);
    st = acc_n;
    wait_until(st + 250);
    #2 rst = 1;
    #1 chk("midrst_core_outs", {27'd0, core_clear, core_step, core_majority, core_in_bit, irq}, 32'd0);
    @(negedge clk);
    rst = 0;
    wb_rd(32'h00, d); chk("midrst_ctrl", d, 32'h0);
    wb_rd(32'h04, d); chk("midrst_key_lo", d, 32'h0);
    wb_rd(32'h10, d); chk("midrst_data", d, 32'h0);
    wb_rd(32'h00, d); chk("midrst_uflow", d, 32'h04);
    wb_wr(32'h00, 32'h4);
    wb_rd(32'h00, d); chk("midrst_uflow_clr", d, 32'h0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
